// File: rtl/mem_stage_ctrl_pkg.sv
// Shared processor definitions: memory-stage FSM encoding and timeout default.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } memState_t;

  localparam int TIMEOUT_DEFAULT = 16;

  // Bits needed to hold a count from 0 to maxCount.
  function automatic int cntWidth(input int maxCount);
    return (maxCount < 2) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request bus between the MEM stage controller and the memory.
interface mem_stage_ctrl_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wrData;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdData;
  logic        mem_done;

  modport master (
    output mem_addr, mem_wrData, mem_rd, mem_wr,
    input  mem_rdData, mem_done
  );

  modport slave (
    input  mem_addr, mem_wrData, mem_rd, mem_wr,
    output mem_rdData, mem_done
  );
endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register built from the standard register cells.

module register_16b #(
  parameter logic [15:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);
  // Loadable 16-bit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end
endmodule

module register_3b #(
  parameter logic [2:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);
  // Loadable 3-bit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end
endmodule

module register_1b #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  // Loadable 1-bit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end
endmodule

module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nxtWbData,
  input  logic [2:0]  nxtWriteRegSel,
  input  logic        nxtIsRegWrite,
  input  logic        nxtIsNotHalt,
  output logic [15:0] wbData,
  output logic [2:0]  writeRegSel,
  output logic        isRegWrite,
  output logic        isNotHalt
);
  // The controller always presents either a real result or a bubble, so
  // every field loads on every cycle. Reset leaves a bubble (not a halt).
  register_16b #(.RESET_VAL(16'h0000)) uWbData (
    .clk(clk), .rst(rst), .en(1'b1), .d(nxtWbData), .q(wbData)
  );
  register_3b #(.RESET_VAL(3'd0)) uWriteRegSel (
    .clk(clk), .rst(rst), .en(1'b1), .d(nxtWriteRegSel), .q(writeRegSel)
  );
  register_1b #(.RESET_VAL(1'b0)) uIsRegWrite (
    .clk(clk), .rst(rst), .en(1'b1), .d(nxtIsRegWrite), .q(isRegWrite)
  );
  register_1b #(.RESET_VAL(1'b1)) uIsNotHalt (
    .clk(clk), .rst(rst), .en(1'b1), .d(nxtIsNotHalt), .q(isNotHalt)
  );
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory requests, stalls the front of the
// pipeline while memory is busy, aborts hung accesses, and fills MEM/WB.
module mem_stage_ctrl
  import proc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            aluResult_EX_MEM,
  input  logic [15:0]            rdData2_EX_MEM,
  input  logic                   isMemRead_EX_MEM,
  input  logic                   isMemWrite_EX_MEM,
  input  logic                   isMemToReg_EX_MEM,
  input  logic                   isRegWrite_EX_MEM,
  input  logic                   isNotHalt_EX_MEM,
  input  logic [2:0]             writeRegSel_EX_MEM,
  mem_stage_ctrl_if.master       memBus,
  output logic                   stall,
  output logic                   err,
  output logic [15:0]            wbData_MEM_WB,
  output logic [2:0]             writeRegSel_MEM_WB,
  output logic                   isRegWrite_MEM_WB,
  output logic                   isNotHalt_MEM_WB
);

  localparam int CNT_W = cntWidth(TIMEOUT);

  memState_t        state, stateNext;
  logic [CNT_W-1:0] busyCnt, busyCntNext;
  logic             errNext;
  logic             req;
  logic             timeout;
  logic [15:0]      nxtWbData;
  logic [2:0]       nxtWriteRegSel;
  logic             nxtIsRegWrite;
  logic             nxtIsNotHalt;

  assign memBus.mem_addr   = aluResult_EX_MEM;
  assign memBus.mem_wrData = rdData2_EX_MEM;

  // State, BUSY cycle counter and the registered error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busyCnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= stateNext;
      busyCnt <= busyCntNext;
      err     <= errNext;
    end
  end

  // Next state, request strobes, stall and error detection.
  always_comb begin
    stateNext     = state;
    busyCntNext   = '0;
    errNext       = 1'b0;
    timeout       = 1'b0;
    req           = 1'b0;
    memBus.mem_rd = 1'b0;
    memBus.mem_wr = 1'b0;

    if (state != HALTED) req = isMemRead_EX_MEM | isMemWrite_EX_MEM;

    // A conflicting read+write is resolved as a write.
    if (req) begin
      memBus.mem_wr = isMemWrite_EX_MEM;
      memBus.mem_rd = isMemRead_EX_MEM & ~isMemWrite_EX_MEM;
    end

    case (state)
      IDLE: begin
        // Conflict and misalignment are flagged once, on the first cycle.
        errNext = req & ((isMemRead_EX_MEM & isMemWrite_EX_MEM) | aluResult_EX_MEM[0]);
        if (req && !memBus.mem_done) stateNext = BUSY;
        else if (!req && !isNotHalt_EX_MEM) stateNext = HALTED;
      end
      BUSY: begin
        if (memBus.mem_done) begin
          stateNext = IDLE;
        end else if (busyCnt == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUSY cycle: give up on the access.
          timeout   = 1'b1;
          errNext   = 1'b1;
          stateNext = IDLE;
        end else begin
          busyCntNext = busyCnt + CNT_W'(1);
        end
      end
      HALTED: stateNext = HALTED;
      default: stateNext = IDLE;
    endcase

    stall = req & ~memBus.mem_done & ~timeout;
  end

  // MEM/WB next value: real result when the stage advances, bubble otherwise.
  always_comb begin
    nxtWbData      = 16'h0000;
    nxtWriteRegSel = 3'd0;
    nxtIsRegWrite  = 1'b0;
    nxtIsNotHalt   = 1'b1;
    if (state != HALTED && !stall) begin
      nxtWbData      = isMemToReg_EX_MEM ? memBus.mem_rdData : aluResult_EX_MEM;
      nxtWriteRegSel = writeRegSel_EX_MEM;
      nxtIsRegWrite  = isRegWrite_EX_MEM & ~timeout;
      nxtIsNotHalt   = isNotHalt_EX_MEM;
    end
  end

  mem_wb_reg uMemWb (
    .clk            (clk),
    .rst            (rst),
    .nxtWbData      (nxtWbData),
    .nxtWriteRegSel (nxtWriteRegSel),
    .nxtIsRegWrite  (nxtIsRegWrite),
    .nxtIsNotHalt   (nxtIsNotHalt),
    .wbData         (wbData_MEM_WB),
    .writeRegSel    (writeRegSel_MEM_WB),
    .isRegWrite     (isRegWrite_MEM_WB),
    .isNotHalt      (isNotHalt_MEM_WB)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl.
module tb_mem_stage_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu, rd2;
  logic        mRd, mWr, m2r, rw, nh;
  logic [2:0]  sel;
  logic        stall, err;
  logic [15:0] wbData;
  logic [2:0]  wbSel;
  logic        wbRw, wbNh;

  int nVec = 0;
  int nMis = 0;
  bit halted = 1'b0;

  mem_stage_ctrl_if memBus ();

  mem_stage_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .aluResult_EX_MEM   (alu),
    .rdData2_EX_MEM     (rd2),
    .isMemRead_EX_MEM   (mRd),
    .isMemWrite_EX_MEM  (mWr),
    .isMemToReg_EX_MEM  (m2r),
    .isRegWrite_EX_MEM  (rw),
    .isNotHalt_EX_MEM   (nh),
    .writeRegSel_EX_MEM (sel),
    .memBus             (memBus),
    .stall              (stall),
    .err                (err),
    .wbData_MEM_WB      (wbData),
    .writeRegSel_MEM_WB (wbSel),
    .isRegWrite_MEM_WB  (wbRw),
    .isNotHalt_MEM_WB   (wbNh)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkBubble(input string tag);
    chk({tag, ".wbData"}, wbData, 16'h0000);
    chk({tag, ".wbSel"}, {13'd0, wbSel}, 16'd0);
    chk({tag, ".wbRw"}, {15'd0, wbRw}, 16'd0);
    chk({tag, ".wbNh"}, {15'd0, wbNh}, 16'd1);
  endtask

  // One instruction held in EX/MEM until it leaves; memory answers after
  // 'lat' cycles (lat > TO means it never answers).
  task automatic runInstr(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic r, input logic w, input logic mr, input logic regw,
                          input logic notHalt, input logic [2:0] s, input int lat,
                          input logic [15:0] ldVal);
    bit isReq, aborted, wasHalted;
    int endIdx;
    logic [15:0] drv;
    logic errExp;
    wasHalted = halted;
    isReq   = (r | w) && !halted;
    aborted = isReq && (lat > TO);
    endIdx  = !isReq ? 0 : ((lat > TO) ? TO : lat);
    alu = a; rd2 = d; mRd = r; mWr = w; m2r = mr; rw = regw; nh = notHalt; sel = s;
    for (int i = 0; i <= endIdx; i++) begin
      drv = (i == lat) ? ldVal : 16'($urandom);
      memBus.mem_rdData = drv;
      memBus.mem_done   = (r | w) && (i == lat);
      #4;
      chk({tag, ".stall"}, {15'd0, stall}, {15'd0, isReq && (i < endIdx)});
      chk({tag, ".mem_rd"}, {15'd0, memBus.mem_rd}, {15'd0, isReq && r && !w});
      chk({tag, ".mem_wr"}, {15'd0, memBus.mem_wr}, {15'd0, isReq && w});
      chk({tag, ".mem_addr"}, memBus.mem_addr, a);
      chk({tag, ".mem_wrData"}, memBus.mem_wrData, d);
      @(posedge clk);
      #1;
      errExp = (i == 0 && isReq && ((r && w) || a[0])) || (aborted && i == endIdx);
      chk({tag, ".err"}, {15'd0, err}, {15'd0, errExp});
      if (wasHalted || (isReq && i < endIdx)) begin
        chkBubble(tag);
      end else if (aborted) begin
        chk({tag, ".abortRw"}, {15'd0, wbRw}, 16'd0);
        chk({tag, ".abortNh"}, {15'd0, wbNh}, {15'd0, notHalt});
      end else begin
        chk({tag, ".wbData"}, wbData, mr ? drv : a);
        chk({tag, ".wbSel"}, {13'd0, wbSel}, {13'd0, s});
        chk({tag, ".wbRw"}, {15'd0, wbRw}, {15'd0, regw});
        chk({tag, ".wbNh"}, {15'd0, wbNh}, {15'd0, notHalt});
      end
    end
    if (!wasHalted && !(r | w) && !notHalt) halted = 1'b1;
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    alu = '0; rd2 = '0; mRd = 0; mWr = 0; m2r = 0; rw = 0; nh = 1; sel = '0;
    memBus.mem_rdData = '0; memBus.mem_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chkBubble(tag);
    chk({tag, ".err"}, {15'd0, err}, 16'd0);
    chk({tag, ".stall"}, {15'd0, stall}, 16'd0);
    rst = 1'b0;
    halted = 1'b0;
  endtask

  initial begin
    int kind, lat;
    logic [15:0] a;
    logic r, w, mr;

    @(posedge clk); #1;
    doReset("reset");

    // ALU result, no memory traffic.
    runInstr("alu", 16'h1234, 16'h0000, 0, 0, 0, 1, 1, 3'd3, 0, 16'h0000);
    // Load with three wait cycles.
    runInstr("load3", 16'h0040, 16'h0000, 1, 0, 1, 1, 1, 3'd5, 3, 16'hBEEF);
    // Zero-wait store.
    runInstr("store", 16'h0010, 16'h55AA, 0, 1, 0, 0, 1, 3'd0, 0, 16'h0000);
    // Memory never answers: timeout abort, then back to normal.
    runInstr("hang", 16'h0020, 16'h0000, 1, 0, 1, 1, 1, 3'd2, 1000, 16'h0000);
    runInstr("afterHang", 16'h4321, 16'h0000, 0, 0, 0, 1, 1, 3'd7, 0, 16'h0000);
    // Answer on the last allowed BUSY cycle and one before it.
    runInstr("lat16", 16'h0100, 16'h0000, 1, 0, 1, 1, 1, 3'd4, 16, 16'hA5A5);
    runInstr("lat15", 16'h0102, 16'h0000, 1, 0, 1, 1, 1, 3'd6, 15, 16'h5A5A);

    // Reset in the middle of a pending load: no writeback.
    alu = 16'h0050; rd2 = '0; mRd = 1; mWr = 0; m2r = 1; rw = 1; nh = 1; sel = 3'd1;
    memBus.mem_done = 1'b0; memBus.mem_rdData = 16'hDEAD;
    #4;
    chk("midRst.stall0", {15'd0, stall}, 16'd1);
    @(posedge clk); #1;
    chkBubble("midRst.c0");
    #4;
    chk("midRst.stall1", {15'd0, stall}, 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chkBubble("midRst.rst");
    chk("midRst.err", {15'd0, err}, 16'd0);
    rst = 1'b0;
    runInstr("postRst", 16'h0052, 16'h0000, 1, 0, 1, 1, 1, 3'd2, 2, 16'h1357);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      a  = 16'($urandom);
      r  = (kind == 1) || (kind == 3);
      w  = (kind == 2) || (kind == 3);
      mr = (kind == 1);
      lat = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 4));
      runInstr("rand", a, 16'($urandom), r, w, mr, 1'($urandom), 1'b1,
               3'($urandom), lat, 16'($urandom));
    end

    // Read+write conflict on an odd address, then halt.
    runInstr("both", 16'h0003, 16'h7777, 1, 1, 0, 0, 1, 3'd1, 2, 16'h0000);
    runInstr("halt", 16'h00AA, 16'h0000, 0, 0, 0, 0, 0, 3'd0, 0, 16'h0000);
    runInstr("hLoad", 16'h0040, 16'h0000, 1, 0, 1, 1, 1, 3'd3, 0, 16'h9999);
    runInstr("hStore", 16'h0041, 16'h1111, 0, 1, 0, 0, 1, 3'd0, 2, 16'h0000);
    runInstr("hAlu", 16'h2222, 16'h0000, 0, 0, 0, 1, 1, 3'd5, 0, 16'h0000);

    // Reset releases HALTED.
    doReset("resetHalt");
    runInstr("afterHalt", 16'h0BCD, 16'h0000, 0, 0, 0, 1, 1, 3'd6, 0, 16'h0000);
    runInstr("afterHaltLd", 16'h0060, 16'h0000, 1, 0, 1, 1, 1, 3'd2, 1, 16'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
